// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter: controller state
// encoding, requester IDs and the legal parameter ranges.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_EXT = 1'b1;

    localparam int RD_LAT_MIN    = 1;
    localparam int RD_LAT_MAX    = 4;
    localparam int MAX_BURST_MIN = 1;
    localparam int MAX_BURST_MAX = 15;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single instruction/data memory port between the CPU and the
// external loader/DMA port. Each access runs IDLE -> ACCESS -> (WAIT) -> DONE,
// the CPU wins ties, and a burst counter guarantees the external port a grant
// after MAX_BURST consecutive CPU grants while it is waiting.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_ack,
    output logic [DATA_W-1:0] ext_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $fatal(1, "mem_port_arbiter: RD_LAT must be within 1..4");
    end
    if (MAX_BURST < MAX_BURST_MIN || MAX_BURST > MAX_BURST_MAX) begin : g_bad_max_burst
        $fatal(1, "mem_port_arbiter: MAX_BURST must be within 1..15");
    end

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);
    localparam logic [2:0] LAT_LOAD    = 3'(RD_LAT - 1);

    state_t            state;
    state_t            state_nxt;
    logic              grant;
    logic              grant_ext;
    logic              own;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [2:0]        lat_cnt;
    logic [3:0]        burst_cnt;
    logic              capture;

    // Next-state logic and arbitration decision (only made in IDLE)
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_ext = 1'b0;
        case (state)
            IDLE: begin
                if (ext_req && (!cpu_req || burst_cnt == BURST_LIMIT)) begin
                    grant     = 1'b1;
                    grant_ext = 1'b1;
                    state_nxt = ACCESS;
                end else if (cpu_req) begin
                    grant     = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (lat_we || RD_LAT == 1) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == 3'd1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the winning request so the requester's inputs may change afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own       <= OWN_CPU;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (grant) begin
            own       <= grant_ext ? OWN_EXT : OWN_CPU;
            lat_we    <= grant_ext ? ext_we : cpu_we;
            lat_addr  <= grant_ext ? ext_addr : cpu_addr;
            lat_wdata <= grant_ext ? ext_wdata : cpu_wdata;
        end
    end

    // Read latency counter: loaded in ACCESS, counts down through WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt <= '0;
        end else if (state == ACCESS && !lat_we && RD_LAT > 1) begin
            lat_cnt <= LAT_LOAD;
        end else if (state == WAIT) begin
            lat_cnt <= lat_cnt - 3'd1;
        end
    end

    // Fairness counter: counts CPU grants that bypassed a waiting external request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
        end else if (grant) begin
            if (grant_ext || !ext_req) begin
                burst_cnt <= '0;
            end else if (burst_cnt != BURST_LIMIT) begin
                burst_cnt <= burst_cnt + 4'd1;
            end
        end
    end

    assign capture = (state_nxt == DONE) && (state != DONE) && !lat_we;

    // Read data is captured on the edge into DONE and held until the same owner reads again
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata <= '0;
            ext_rdata <= '0;
        end else if (capture) begin
            if (own == OWN_EXT) begin
                ext_rdata <= mem_rdata;
            end else begin
                cpu_rdata <= mem_rdata;
            end
        end
    end

    assign cpu_ack   = (state == DONE) && (own == OWN_CPU);
    assign ext_ack   = (state == DONE) && (own == OWN_EXT);
    assign cpu_stall = cpu_req & ~cpu_ack;
    assign mem_we    = (state == ACCESS) && lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (RD_LAT 2, 4, 1), each with its
// own latency-accurate memory model, driven by a transaction table plus
// hand-written arbitration, starvation and reset sequences.
module tb_mem_port_arbiter;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        cpu_req   [N];
    logic        cpu_we    [N];
    logic [31:0] cpu_addr  [N];
    logic [31:0] cpu_wdata [N];
    logic        cpu_ack   [N];
    logic [31:0] cpu_rdata [N];
    logic        cpu_stall [N];
    logic        ext_req   [N];
    logic        ext_we    [N];
    logic [31:0] ext_addr  [N];
    logic [31:0] ext_wdata [N];
    logic        ext_ack   [N];
    logic [31:0] ext_rdata [N];
    logic [31:0] mem_addr  [N];
    logic        mem_we    [N];
    logic [31:0] mem_wdata [N];
    logic [31:0] mem_rdata [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : {~a[15:0], a[15:0]};
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 4 : 1);
        logic [31:0] pipe [4];

        mem_port_arbiter #(
            .ADDR_W   (32),
            .DATA_W   (32),
            .RD_LAT   (LAT),
            .MAX_BURST(4)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .cpu_req  (cpu_req[g]),
            .cpu_we   (cpu_we[g]),
            .cpu_addr (cpu_addr[g]),
            .cpu_wdata(cpu_wdata[g]),
            .cpu_ack  (cpu_ack[g]),
            .cpu_rdata(cpu_rdata[g]),
            .cpu_stall(cpu_stall[g]),
            .ext_req  (ext_req[g]),
            .ext_we   (ext_we[g]),
            .ext_addr (ext_addr[g]),
            .ext_wdata(ext_wdata[g]),
            .ext_ack  (ext_ack[g]),
            .ext_rdata(ext_rdata[g]),
            .mem_addr (mem_addr[g]),
            .mem_we   (mem_we[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g])
        );

        // Memory model: data for the address presented in the address cycle
        // is visible during the last cycle before the controller enters DONE.
        always @(posedge clk) begin
            pipe[0] <= mem_fn(mem_addr[g]);
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end
        assign mem_rdata[g] = (LAT == 1) ? mem_fn(mem_addr[g]) : pipe[(LAT >= 2) ? LAT - 2 : 0];
    end

    typedef struct {
        int          d;
        bit          ext;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_zero_outputs(input int d, input string tag);
        chk($sformatf("%s d%0d cpu_ack", tag, d), 32'(cpu_ack[d]), 32'h0);
        chk($sformatf("%s d%0d ext_ack", tag, d), 32'(ext_ack[d]), 32'h0);
        chk($sformatf("%s d%0d cpu_rdata", tag, d), cpu_rdata[d], 32'h0);
        chk($sformatf("%s d%0d ext_rdata", tag, d), ext_rdata[d], 32'h0);
        chk($sformatf("%s d%0d mem_addr", tag, d), mem_addr[d], 32'h0);
        chk($sformatf("%s d%0d mem_we", tag, d), 32'(mem_we[d]), 32'h0);
        chk($sformatf("%s d%0d mem_wdata", tag, d), mem_wdata[d], 32'h0);
    endtask

    // One access from the IDLE state, checked against the table row.
    task automatic run_txn(input vec_t v, input int row);
        int          cyc;
        bit          got;
        bit          own_ack;
        int          we_cnt;
        bit          stall_ok;
        bit          other_ack;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [31:0] rd;
        cyc = 0; got = 0; we_cnt = 0; stall_ok = 1; other_ack = 0;
        wa = '0; wd = '0; rd = '0;
        if (v.ext) begin
            ext_req[v.d] = 1'b1; ext_we[v.d] = v.we; ext_addr[v.d] = v.addr; ext_wdata[v.d] = v.wdata;
        end else begin
            cpu_req[v.d] = 1'b1; cpu_we[v.d] = v.we; cpu_addr[v.d] = v.addr; cpu_wdata[v.d] = v.wdata;
        end
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (mem_we[v.d]) begin
                we_cnt++; wa = mem_addr[v.d]; wd = mem_wdata[v.d];
            end
            if (v.ext ? cpu_ack[v.d] : ext_ack[v.d]) other_ack = 1;
            own_ack = v.ext ? ext_ack[v.d] : cpu_ack[v.d];
            if (!v.ext && (cpu_stall[v.d] == own_ack)) stall_ok = 0;
            if (own_ack) begin
                got = 1;
                rd  = v.ext ? ext_rdata[v.d] : cpu_rdata[v.d];
            end
        end
        if (v.ext) ext_req[v.d] = 1'b0;
        else       cpu_req[v.d] = 1'b0;
        chk($sformatf("row%0d ack seen", row), 32'(got), 32'h1);
        chk($sformatf("row%0d latency", row), cyc, v.lat);
        chk($sformatf("row%0d mem_we cycles", row), we_cnt, v.we ? 1 : 0);
        if (v.we) begin
            chk($sformatf("row%0d write addr", row), wa, v.addr);
            chk($sformatf("row%0d write data", row), wd, v.wdata);
        end else begin
            chk($sformatf("row%0d rdata", row), rd, v.rdata);
        end
        chk($sformatf("row%0d other ack", row), 32'(other_ack), 32'h0);
        if (!v.ext) chk($sformatf("row%0d cpu_stall", row), 32'(stall_ok), 32'h1);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        vec_t vecs[8];
        int   cyc;
        int   cpu_at;
        int   ext_at;
        logic [31:0] cpu_rd;
        logic [31:0] ext_rd;
        int   order[7];
        int   exp_order[7];
        int   n;
        bit   early_ack;

        vecs[0] = '{d:0, ext:0, we:0, addr:32'h40,  wdata:32'h0,        lat:3, rdata:32'hDEADBEEF};
        vecs[1] = '{d:0, ext:1, we:1, addr:32'h100, wdata:32'h12345678, lat:2, rdata:32'h0};
        vecs[2] = '{d:0, ext:0, we:1, addr:32'h200, wdata:32'hCAFEF00D, lat:2, rdata:32'h0};
        vecs[3] = '{d:0, ext:1, we:0, addr:32'h80,  wdata:32'h0,        lat:3, rdata:32'hFF7F0080};
        vecs[4] = '{d:2, ext:0, we:0, addr:32'h0,   wdata:32'h0,        lat:2, rdata:32'hFFFF0000};
        vecs[5] = '{d:2, ext:0, we:0, addr:32'h4,   wdata:32'h0,        lat:2, rdata:32'hFFFB0004};
        vecs[6] = '{d:1, ext:1, we:0, addr:32'h44,  wdata:32'h0,        lat:5, rdata:32'hFFBB0044};
        vecs[7] = '{d:1, ext:0, we:1, addr:32'h8,   wdata:32'hA5A5A5A5, lat:2, rdata:32'h0};
        exp_order = '{0, 0, 0, 0, 1, 0, 0};

        for (int i = 0; i < N; i++) begin
            cpu_req[i] = 0; cpu_we[i] = 0; cpu_addr[i] = '0; cpu_wdata[i] = '0;
            ext_req[i] = 0; ext_we[i] = 0; ext_addr[i] = '0; ext_wdata[i] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) chk_zero_outputs(i, "reset");
        chk("reset burst_cnt", 32'(g_dut[0].u_dut.burst_cnt), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven single accesses
        for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

        // Read data registers hold across other owners' traffic and writes
        chk("hold cpu_rdata", cpu_rdata[0], 32'hDEADBEEF);
        chk("hold ext_rdata", ext_rdata[0], 32'hFF7F0080);

        // Simultaneous reads: CPU first, EXT after one idle cycle
        cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 32'h10;
        ext_req[0] = 1; ext_we[0] = 0; ext_addr[0] = 32'h20;
        cyc = 0; cpu_at = -1; ext_at = -1; cpu_rd = '0; ext_rd = '0;
        while (ext_at < 0 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (cpu_ack[0] && cpu_at < 0) begin
                cpu_at = cyc; cpu_rd = cpu_rdata[0]; cpu_req[0] = 0;
            end
            if (ext_ack[0]) begin
                ext_at = cyc; ext_rd = ext_rdata[0]; ext_req[0] = 0;
            end
        end
        cpu_req[0] = 0; ext_req[0] = 0;
        chk("tie cpu_ack cycle", cpu_at, 3);
        chk("tie ext_ack cycle", ext_at, 7);
        chk("tie cpu_rdata", cpu_rd, 32'hFFEF0010);
        chk("tie ext_rdata", ext_rd, 32'hFFDF0020);
        @(negedge clk);

        // Starvation bound: both requests held continuously
        for (int i = 0; i < 7; i++) order[i] = -1;
        cpu_req[0] = 1; cpu_addr[0] = 32'h10;
        ext_req[0] = 1; ext_addr[0] = 32'h20;
        n = 0; cyc = 0;
        while (n < 7 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (cpu_ack[0]) begin
                order[n] = 0;
                if (n == 3) chk("burst_cnt at limit", 32'(g_dut[0].u_dut.burst_cnt), 32'h4);
                n++;
            end else if (ext_ack[0]) begin
                order[n] = 1;
                chk("burst_cnt after ext", 32'(g_dut[0].u_dut.burst_cnt), 32'h0);
                n++;
            end
        end
        cpu_req[0] = 0; ext_req[0] = 0;
        chk("starve grant count", n, 7);
        for (int i = 0; i < 7; i++) chk($sformatf("starve grant %0d", i), order[i], exp_order[i]);
        repeat (8) @(negedge clk);

        // Reset during WAIT on the RD_LAT=4 instance
        cpu_req[1] = 1; cpu_we[1] = 0; cpu_addr[1] = 32'h30;
        early_ack = 0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_ack[1]) early_ack = 1;
        end
        chk("pre-reset no ack", 32'(early_ack), 32'h0);
        chk("pre-reset mem_addr", mem_addr[1], 32'h30);
        rst_n = 1'b0;
        #1;
        chk_zero_outputs(1, "midreset");
        early_ack = 0;
        repeat (2) begin
            @(negedge clk);
            if (cpu_ack[1]) early_ack = 1;
        end
        chk("in-reset no ack", 32'(early_ack), 32'h0);
        rst_n = 1'b1;
        cyc = 0; cpu_at = -1; cpu_rd = '0;
        while (cpu_at < 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cpu_ack[1]) begin
                cpu_at = cyc; cpu_rd = cpu_rdata[1];
            end
        end
        cpu_req[1] = 0;
        chk("post-reset latency", cpu_at, 5);
        chk("post-reset rdata", cpu_rd, 32'hFFCF0030);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates the single unified instruction/data memory port between two requesters: the multicycle CPU (fetch and load/store traffic) and the external loader/DMA port (program download, peripheral buffers). The block sequences each access through a small FSM and honours the memory's fixed read latency. It stalls the CPU while its access is pending. CPU has default priority, and a fairness counter bounds how long the external port can be starved.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
RD_LAT, 1, memory read latency in cycles (legal 1..4)
MAX_BURST, 4, max consecutive CPU grants while ext_req is pending (legal 1..15)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  CPU access request; level, held with stable addr/we/wdata until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU byte address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  registered read data, valid while cpu_ack = 1
cpu_stall  out  1  combinational cpu_req & ~cpu_ack; the main controller freezes its state while this is high
ext_req, ext_we, ext_addr, ext_wdata  in  1/1/ADDR_W/DATA_W  external port, same protocol as the CPU port
ext_ack  out  1  one-cycle completion pulse
ext_rdata  out  DATA_W  registered read data, valid while ext_ack = 1
mem_addr  out  ADDR_W  memory address
mem_we  out  1  memory write strobe
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after the address cycle

Behaviour:
- Reset: clk and rst_n as already decided — reset rst_n, asynchronous, active-low; clock clk.
  - State goes to IDLE.
  - All outputs are 0: acks, rdata registers, mem_addr, mem_we, mem_wdata.
  - Fairness counter and latency counter are 0.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE
  - Requests are sampled only in IDLE.
  - Owner select: if ext_req && (!cpu_req || burst_cnt == MAX_BURST), owner = EXT; else if cpu_req, owner = CPU.
  - Latch owner, we, addr and wdata into registers, then go to ACCESS.
  - No request: stay in IDLE.
- ACCESS (exactly 1 cycle)
  - mem_addr/mem_wdata come from the latched registers; mem_we = latched we.
  - Write: go to DONE.
  - Read with RD_LAT == 1: go to DONE.
  - Read with RD_LAT > 1: load lat_cnt = RD_LAT-1, go to WAIT.
- WAIT
  - mem_addr is held and mem_we = 0.
  - lat_cnt decrements each cycle; on the cycle it reaches 1, go to DONE.
- Read data capture: mem_rdata is captured into the owner's rdata register on the transition into DONE. Rdata registers hold their value until the next read by the same owner.
- DONE (1 cycle)
  - Owner's ack = 1; mem_we = 0; then go to IDLE.
- Latency, req sampled in IDLE to ack: write = 2 cycles; read = 1+RD_LAT cycles. One idle (arbitration) cycle separates consecutive accesses.
- Requester obligation: drop req in the cycle after ack unless a new access is intended. A req still high in IDLE is treated as a new access.
- mem_we is 1 only in ACCESS with a latched write: exactly one cycle per write. In IDLE, mem_addr/mem_wdata hold their last values.
- Fairness counter (burst_cnt, 4 bits):
  - CPU grant while ext_req = 1: burst_cnt increments, saturating at MAX_BURST.
  - CPU grant while ext_req = 0: burst_cnt clears.
  - Any EXT grant: burst_cnt clears.
- Simultaneous requests with burst_cnt < MAX_BURST: CPU wins.
- Req dropped mid-access (protocol violation): the access still completes and ack still pulses. No abort.
- Reset asserted mid-access: immediate abort. mem_we drops asynchronously and no ack is issued. After release, pending requests are arbitrated fresh.
- Out-of-range parameters are rejected by elaboration-time checks that stop elaboration.

Decomposition:
- Shared controller package holds:
  - state encoding localparams (IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, DONE=2'd3);
  - owner IDs (OWN_CPU=1'b0, OWN_EXT=1'b1);
  - the RD_LAT/MAX_BURST legal ranges.
- No sub-module. The latency counter and fairness counter are inline; both are smaller than a module boundary justifies.

Test Plan:
- CPU read alone, RD_LAT=2, addr 0x40, mem returns 0xDEADBEEF -> cpu_ack exactly 3 cycles after the IDLE sample, cpu_rdata=0xDEADBEEF, mem_we never 1, cpu_stall high until the ack cycle.
- EXT write, addr 0x100, data 0x12345678 -> mem_we high exactly one cycle with those addr/data values; ext_ack 2 cycles after the sample; cpu_ack stays 0.
- cpu_req and ext_req rise together (both reads) -> CPU served first; ext_ack follows one idle cycle after cpu_ack; CPU drops req after its ack.
- Starvation: cpu_req and ext_req held continuously, MAX_BURST=4 -> grant order CPU,CPU,CPU,CPU,EXT,CPU...; burst_cnt returns to 0 after the EXT grant.
- rst_n pulsed low during WAIT (RD_LAT=4) -> no ack; all outputs 0 immediately; after release, a held cpu_req completes normally in 5 cycles.
- RD_LAT=1, back-to-back CPU reads at 0x0 then 0x4 -> acks 2 cycles after each sample, and each rdata matches the memory model for its address.
